// File: rtl/bcd_down_timer.sv
// Two-digit BCD countdown timer with load, pause, and on-the-fly subtraction.
// A single shared BCD subtractor handles plain ticks (subtract 0 with borrow-in),
// sub requests, and a sub request coinciding with a tick (borrow-in folds the tick in).
module bcd_down_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_ten,
    input  logic [3:0] load_unit,
    input  logic       tick,
    input  logic       hold,
    input  logic       sub_req,
    input  logic [3:0] sub_ten,
    input  logic [3:0] sub_unit,
    output logic       sub_ack,
    output logic [3:0] ten,
    output logic [3:0] unit,
    output logic       running,
    output logic       expired,
    output logic       bad_bcd
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0] state, state_nx;
    logic [3:0] ten_nx, unit_nx;
    logic       exp_nx, ack_nx, bad_nx;

    logic       load_ok, sub_ok, tick_eff, cin;
    logic [3:0] op_ten, op_unit;
    logic [4:0] u_diff, t_diff;
    logic       u_brw, t_brw, hit_zero;
    logic [3:0] u_res, t_res;

    assign load_ok  = (load_ten <= 4'd9) && (load_unit <= 4'd9);
    assign sub_ok   = (sub_ten  <= 4'd9) && (sub_unit  <= 4'd9);
    assign tick_eff = tick && !hold && (state == RUN);

    // Digit-wise BCD subtract of the selected operand plus optional tick borrow-in
    always_comb begin
        op_ten  = (sub_req && !load) ? sub_ten  : 4'd0;
        op_unit = (sub_req && !load) ? sub_unit : 4'd0;
        cin     = tick_eff;
        u_diff  = {1'b0, unit} - {1'b0, op_unit} - {4'd0, cin};
        u_brw   = u_diff[4];
        u_res   = u_brw ? (u_diff[3:0] + 4'd10) : u_diff[3:0];
        t_diff  = {1'b0, ten} - {1'b0, op_ten} - {4'd0, u_brw};
        t_brw   = t_diff[4];
        t_res   = t_brw ? (t_diff[3:0] + 4'd10) : t_diff[3:0];
        // A borrow out of the tens digit means the result went negative: floor at 00
        hit_zero = t_brw || ((t_res == 4'd0) && (u_res == 4'd0));
    end

    // Next-state / next-output selection with load > sub_req > tick priority
    always_comb begin
        state_nx = state;
        ten_nx   = ten;
        unit_nx  = unit;
        exp_nx   = 1'b0;
        ack_nx   = 1'b0;
        bad_nx   = 1'b0;
        if (load) begin
            if (!load_ok) begin
                bad_nx = 1'b1;
            end else begin
                ten_nx  = load_ten;
                unit_nx = load_unit;
                if ((load_ten == 4'd0) && (load_unit == 4'd0)) begin
                    state_nx = DONE;
                    exp_nx   = 1'b1;
                end else begin
                    state_nx = RUN;
                end
            end
        end else if (sub_req) begin
            if (!sub_ok) begin
                bad_nx = 1'b1;
            end else begin
                ack_nx = 1'b1;
                if (state == RUN) begin
                    if (hit_zero) begin
                        ten_nx   = 4'd0;
                        unit_nx  = 4'd0;
                        state_nx = DONE;
                        exp_nx   = 1'b1;
                    end else begin
                        ten_nx  = t_res;
                        unit_nx = u_res;
                    end
                end
            end
        end else if (tick_eff) begin
            if (hit_zero) begin
                ten_nx   = 4'd0;
                unit_nx  = 4'd0;
                state_nx = DONE;
                exp_nx   = 1'b1;
            end else begin
                ten_nx  = t_res;
                unit_nx = u_res;
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ten     <= 4'd0;
            unit    <= 4'd0;
            running <= 1'b0;
            expired <= 1'b0;
            sub_ack <= 1'b0;
            bad_bcd <= 1'b0;
        end else begin
            state   <= state_nx;
            ten     <= ten_nx;
            unit    <= unit_nx;
            running <= (state_nx == RUN);
            expired <= exp_nx;
            sub_ack <= ack_nx;
            bad_bcd <= bad_nx;
        end
    end

endmodule

// File: tb/tb_bcd_down_timer.sv
// Bench for bcd_down_timer: decimal-integer reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_bcd_down_timer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load = 0, tick = 0, hold = 0, sub_req = 0;
    logic [3:0] load_ten = 0, load_unit = 0, sub_ten = 0, sub_unit = 0;
    logic       sub_ack, running, expired, bad_bcd;
    logic [3:0] ten, unit;

    int errors = 0;
    int checks = 0;

    bcd_down_timer dut (
        .clk(clk), .rst_n(rst_n), .load(load), .load_ten(load_ten), .load_unit(load_unit),
        .tick(tick), .hold(hold), .sub_req(sub_req), .sub_ten(sub_ten), .sub_unit(sub_unit),
        .sub_ack(sub_ack), .ten(ten), .unit(unit), .running(running), .expired(expired),
        .bad_bcd(bad_bcd)
    );

    always #5 clk = ~clk;

    // Reference model: remaining time as a plain integer, mode 0=idle 1=run 2=done
    int m_val, m_mode;
    logic m_exp, m_ack, m_bad;
    int amt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_val <= 0; m_mode <= 0; m_exp <= 0; m_ack <= 0; m_bad <= 0;
        end else begin
            m_exp <= 0; m_ack <= 0; m_bad <= 0;
            if (load) begin
                if (load_ten > 9 || load_unit > 9) m_bad <= 1;
                else begin
                    m_val <= load_ten * 10 + load_unit;
                    if (load_ten * 10 + load_unit == 0) begin m_mode <= 2; m_exp <= 1; end
                    else m_mode <= 1;
                end
            end else if (sub_req) begin
                if (sub_ten > 9 || sub_unit > 9) m_bad <= 1;
                else begin
                    m_ack <= 1;
                    if (m_mode == 1) begin
                        amt = sub_ten * 10 + sub_unit + ((tick && !hold) ? 1 : 0);
                        if (m_val - amt <= 0) begin m_val <= 0; m_mode <= 2; m_exp <= 1; end
                        else m_val <= m_val - amt;
                    end
                end
            end else if (tick && !hold && m_mode == 1) begin
                if (m_val - 1 <= 0) begin m_val <= 0; m_mode <= 2; m_exp <= 1; end
                else m_val <= m_val - 1;
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        check("model_ten", int'(ten), m_val / 10);
        check("model_unit", int'(unit), m_val % 10);
        check("model_running", int'(running), (m_mode == 1) ? 1 : 0);
        check("model_expired", int'(expired), int'(m_exp));
        check("model_sub_ack", int'(sub_ack), int'(m_ack));
        check("model_bad_bcd", int'(bad_bcd), int'(m_bad));
    end

    // One cycle of stimulus; pulse inputs are cleared right after the sampling edge
    task automatic step(input logic l, input logic [3:0] lt, input logic [3:0] lu,
                        input logic t, input logic s, input logic [3:0] st, input logic [3:0] su);
        @(negedge clk);
        load = l; load_ten = lt; load_unit = lu; tick = t;
        sub_req = s; sub_ten = st; sub_unit = su;
        @(posedge clk);
        #1;
        load = 0; tick = 0; sub_req = 0;
    endtask

    task automatic do_load(input logic [3:0] lt, input logic [3:0] lu);
        step(1, lt, lu, 0, 0, 0, 0);
    endtask

    task automatic do_tick();
        step(0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic do_sub(input logic [3:0] st, input logic [3:0] su, input logic t);
        step(0, 0, 0, t, 1, st, su);
    endtask

    task automatic do_idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic int val();
        return int'(ten) * 10 + int'(unit);
    endfunction

    initial begin
        rst_n = 1;
        #1 rst_n = 0;
        #20;
        @(negedge clk);
        rst_n = 1;
        check("reset_val", val(), 0);
        check("reset_running", int'(running), 0);

        // Idle ignores ticks and stays put
        do_tick();
        check("idle_tick_val", val(), 0);
        check("idle_tick_running", int'(running), 0);

        // Invalid load then load 00
        do_load(4'd0, 4'hA);
        check("badload_bad", int'(bad_bcd), 1);
        check("badload_running", int'(running), 0);
        check("badload_val", val(), 0);
        do_load(4'd0, 4'd0);
        check("load00_expired", int'(expired), 1);
        check("load00_running", int'(running), 0);
        do_idle();
        check("load00_exp_once", int'(expired), 0);

        // Load 25 and count through zero
        do_load(4'd2, 4'd5);
        check("l25_val", val(), 25);
        check("l25_running", int'(running), 1);
        for (int i = 1; i <= 24; i++) begin
            do_tick();
            check("cnt_val", val(), 25 - i);
            check("cnt_expired", int'(expired), 0);
        end
        do_tick();
        check("cnt_zero_val", val(), 0);
        check("cnt_zero_running", int'(running), 0);
        check("cnt_zero_expired", int'(expired), 1);
        do_tick();
        check("cnt_26_val", val(), 0);
        check("cnt_26_expired", int'(expired), 0);

        // Sub in done: ack only
        do_sub(4'd0, 4'd3, 0);
        check("done_sub_ack", int'(sub_ack), 1);
        check("done_sub_val", val(), 0);

        // Load 30, sub 12, sub 20
        do_load(4'd3, 4'd0);
        do_sub(4'd1, 4'd2, 0);
        check("sub12_val", val(), 18);
        check("sub12_ack", int'(sub_ack), 1);
        do_idle();
        check("sub12_ack_drop", int'(sub_ack), 0);
        do_sub(4'd2, 4'd0, 0);
        check("sub20_val", val(), 0);
        check("sub20_expired", int'(expired), 1);
        check("sub20_ack", int'(sub_ack), 1);
        check("sub20_running", int'(running), 0);

        // Load 10, sub 04 with tick
        do_load(4'd1, 4'd0);
        do_sub(4'd0, 4'd4, 1);
        check("subtick_val", val(), 5);
        check("subtick_ack", int'(sub_ack), 1);
        do_idle();
        check("subtick_ack_once", int'(sub_ack), 0);

        // Borrow across digits: 43 - 17 - tick = 25
        do_load(4'd4, 4'd3);
        do_sub(4'd1, 4'd7, 1);
        check("borrow_val", val(), 25);
        // Invalid sub operand in run
        do_sub(4'd1, 4'hB, 1);
        check("badsub_bad", int'(bad_bcd), 1);
        check("badsub_ack", int'(sub_ack), 0);
        check("badsub_val", val(), 25);
        // Exact subtract to zero
        do_sub(4'd2, 4'd5, 0);
        check("exact_val", val(), 0);
        check("exact_expired", int'(expired), 1);

        // Load overrides sub and tick
        do_load(4'd6, 4'd0);
        step(1, 4'd3, 4'd3, 1, 1, 4'd0, 4'd1);
        check("loadprio_val", val(), 33);
        check("loadprio_ack", int'(sub_ack), 0);

        // Hold pauses
        do_load(4'd4, 4'd0);
        hold = 1;
        for (int i = 0; i < 5; i++) do_tick();
        check("hold_val", val(), 40);
        hold = 0;
        do_tick();
        check("unhold_val", val(), 39);

        // Reset mid-count
        do_load(4'd5, 4'd0);
        for (int i = 0; i < 3; i++) do_tick();
        check("pre_rst_val", val(), 47);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("rst_val", val(), 0);
        check("rst_running", int'(running), 0);
        check("rst_expired", int'(expired), 0);
        @(negedge clk);
        rst_n = 1;
        do_tick();
        check("post_rst_val", val(), 0);
        check("post_rst_running", int'(running), 0);
        check("post_rst_expired", int'(expired), 0);

        do_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
